// File: rtl/seq_mult_core.sv
// Iterative 32x32->64 shift-add multiplier: one product per init rising edge, 32-cycle latency.
// Optional macro MULT_SIGNED_EN switches to two's-complement operands (magnitude multiply + final negate).
module seq_mult_core #(
    parameter int unsigned freq_hz = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic        init,
    output logic        ready,
    output logic [31:0] res_up,
    output logic [31:0] res_dn
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic        init_q;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    logic [63:0] sum;
    logic [63:0] product;
    logic [31:0] op_a;
    logic [31:0] op_b;

    // freq_hz only exists so the peripheral wrapper can pass its clock rate through.
    logic [31:0] unused_freq;
    assign unused_freq = freq_hz;

`ifdef MULT_SIGNED_EN
    logic sign_q;
`endif

    always_comb begin
        sum     = acc + (mplier[0] ? mcand : 64'd0);
        product = sum;
        op_a    = A_in;
        op_b    = B_in;
`ifdef MULT_SIGNED_EN
        // -2^31 maps to magnitude 2^31, which is still exact as an unsigned 32-bit value.
        op_a    = A_in[31] ? -A_in : A_in;
        op_b    = B_in[31] ? -B_in : B_in;
        product = sign_q ? -sum : sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            init_q <= 1'b1;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            ready  <= 1'b0;
            res_up <= 32'd0;
            res_dn <= 32'd0;
`ifdef MULT_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            init_q <= init;
            case (state)
                IDLE: begin
                    if (init && !init_q) begin
                        mcand  <= {32'd0, op_a};
                        mplier <= op_b;
                        acc    <= 64'd0;
                        cnt    <= 5'd0;
                        ready  <= 1'b0;
                        state  <= BUSY;
`ifdef MULT_SIGNED_EN
                        sign_q <= A_in[31] ^ B_in[31];
`endif
                    end
                end
                BUSY: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        res_up <= product[63:32];
                        res_dn <= product[31:0];
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: directed corner cases plus randomized operations
// against an arithmetic reference model (honours MULT_SIGNED_EN when defined).
module tb_seq_mult_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        ready;
    logic [31:0] res_up;
    logic [31:0] res_dn;

    int vectors     = 0;
    int miscompares = 0;

    logic        model_ready;
    logic [63:0] model_res;

    seq_mult_core #(.freq_hz(25000000)) dut (
        .clk    (clk),
        .rst    (rst),
        .A_in   (A_in),
        .B_in   (B_in),
        .init   (init),
        .ready  (ready),
        .res_up (res_up),
        .res_dn (res_dn)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
`ifdef MULT_SIGNED_EN
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
`else
        sa = {32'd0, a};
        sb = {32'd0, b};
        return sa * sb;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_ready"}, {63'd0, ready}, {63'd0, model_ready});
        checkOutput({tag, "_res"}, {res_up, res_dn}, model_res);
    endtask

    // Runs one full operation; with disturb set, operands change and init re-rises mid-operation.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [63:0] expected;
        A_in = a;
        B_in = b;
        init = 1'b0;
        tick();
        init = 1'b1;
        tick();
        expected    = refProduct(a, b);
        model_ready = 1'b0;
        checkState("start");
        for (int i = 1; i <= 32; i++) begin
            if (disturb) begin
                if (i == 5) begin
                    A_in = $urandom;
                    B_in = $urandom;
                end
                if (i == 9)  init = 1'b0;
                if (i == 10) init = 1'b1;
            end
            tick();
            if (i == 32) begin
                model_ready = 1'b1;
                model_res   = expected;
            end
            if (i == 31) checkState("busy_hold");
            if (i == 32) checkState("done");
        end
    endtask

    task automatic holdCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            checkState(tag);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        A_in = 32'd0;
        B_in = 32'd0;
        model_ready = 1'b0;
        model_res   = 64'd0;
        tick();
        tick();
        checkState("reset");
        rst = 1'b0;
        tick();
        checkState("post_reset");

        applyStimulus(32'd3, 32'd5, 1'b0);
        checkOutput("spec_3x5", {res_up, res_dn}, 64'h0000_0000_0000_000F);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`ifdef MULT_SIGNED_EN
        checkOutput("spec_m1xm1", {res_up, res_dn}, 64'h0000_0000_0000_0001);
        applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b0);
        checkOutput("spec_m3x5", {res_up, res_dn}, 64'hFFFF_FFFF_FFFF_FFF1);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("spec_min_sq", {res_up, res_dn}, 64'h4000_0000_0000_0000);
`else
        checkOutput("spec_max_sq", {res_up, res_dn}, 64'hFFFF_FFFE_0000_0001);
`endif

        // Mid-operation operand change and init re-rise are ignored; no second operation follows.
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        holdCycles(40, "no_requeue");

        // Reset 10 edges into an operation with init held high.
        A_in = 32'hDEAD_BEEF;
        B_in = 32'h0000_1001;
        init = 1'b0;
        tick();
        init = 1'b1;
        tick();
        model_ready = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        rst = 1'b1;
        tick();
        model_ready = 1'b0;
        model_res   = 64'd0;
        checkState("mid_reset");
        rst = 1'b0;
        holdCycles(40, "reset_init_high");

        applyStimulus(32'd7, 32'd9, 1'b0);
        holdCycles(100, "hold_high");
        applyStimulus(32'd0, $urandom, 1'b0);
        checkOutput("zero_operand", {res_up, res_dn}, 64'd0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(pickOperand(), pickOperand(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) holdCycles($urandom_range(1, 4), "idle_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
